// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RISC-V decode stage: IF/ID register, register file, immediate/control decode, ID/EX register.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle writeback data to register reads.
module decode_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    instr_f,
    input  logic [ADDRESS_WIDTH-1:0] pc_f,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
    input  logic                     stall_d,
    input  logic                     flush_d,
    input  logic                     flush_e,
    input  logic                     reg_write_w,
    input  logic [4:0]               rd_w,
    input  logic [DATA_WIDTH-1:0]    result_w,
    output logic [4:0]               rs1_d,
    output logic [4:0]               rs2_d,
    output logic [DATA_WIDTH-1:0]    rd1_e,
    output logic [DATA_WIDTH-1:0]    rd2_e,
    output logic [DATA_WIDTH-1:0]    imm_e,
    output logic [ADDRESS_WIDTH-1:0] pc_e,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
    output logic [4:0]               rs1_e,
    output logic [4:0]               rs2_e,
    output logic [4:0]               rd_e,
    output logic [9:0]               ctrl_e
);

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [DATA_WIDTH-1:0]    instr_d;
    logic [ADDRESS_WIDTH-1:0] pc_d;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_d;
    logic [DATA_WIDTH-1:0]    rf [32];
    logic [DATA_WIDTH-1:0]    rd1_d;
    logic [DATA_WIDTH-1:0]    rd2_d;
    logic [DATA_WIDTH-1:0]    imm_d;
    logic [31:0]              imm32;
    logic [9:0]               ctrl_d;
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic [4:0]               rd_d;

    assign opcode = instr_d[6:0];
    assign funct3 = instr_d[14:12];
    assign rd_d   = instr_d[11:7];
    assign rs1_d  = instr_d[19:15];
    assign rs2_d  = instr_d[24:20];

    // IF/ID: flush beats stall so a squashed slot never survives a stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
        end else if (flush_d) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
        end else if (!stall_d) begin
            instr_d    <= instr_f;
            pc_d       <= pc_f;
            pc_plus4_d <= pc_plus4_f;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (reg_write_w && (rd_w != 5'd0)) begin
            rf[rd_w] <= result_w;
        end
    end

    always_comb begin
        rd1_d = (rs1_d == 5'd0) ? '0 : rf[rs1_d];
        rd2_d = (rs2_d == 5'd0) ? '0 : rf[rs2_d];
`ifdef DECODE_WB_BYPASS_EN
        if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs1_d)) begin
            rd1_d = result_w;
        end
        if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs2_d)) begin
            rd2_d = result_w;
        end
`endif
    end

    always_comb begin
        imm32 = 32'd0;
        case (opcode)
            OP_LOAD, OP_IMM: imm32 = {{20{instr_d[31]}}, instr_d[31:20]};
            OP_STORE:        imm32 = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
            OP_BRANCH:       imm32 = {{19{instr_d[31]}}, instr_d[31], instr_d[7],
                                      instr_d[30:25], instr_d[11:8], 1'b0};
            OP_JAL:          imm32 = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12],
                                      instr_d[20], instr_d[30:21], 1'b0};
            OP_LUI:          imm32 = {instr_d[31:12], 12'd0};
            default:         imm32 = 32'd0;
        endcase
        imm_d = DATA_WIDTH'($signed(imm32));
    end

    function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic is_sub);
        case (f3)
            3'b000:  alu_op = is_sub ? 3'b001 : 3'b000;
            3'b010:  alu_op = 3'b101;
            3'b110:  alu_op = 3'b011;
            3'b111:  alu_op = 3'b010;
            default: alu_op = 3'b000;
        endcase
    endfunction

    // ctrl layout: {alu_ctrl[2:0], result_src[1:0], alu_src, jump, branch, mem_write, reg_write}
    always_comb begin
        ctrl_d = 10'd0;
        case (opcode)
            OP_LOAD:   ctrl_d = {3'b000, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
            OP_STORE:  ctrl_d = {3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_REG:    ctrl_d = {alu_op(funct3, instr_d[30]), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            OP_IMM:    ctrl_d = {alu_op(funct3, 1'b0), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            OP_BRANCH: ctrl_d = {3'b001, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            OP_JAL:    ctrl_d = {3'b000, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
            default:   ctrl_d = 10'd0;
        endcase
    end

    // ID/EX: a bubble only needs ctrl and rd cleared; data fields pass through
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd1_e      <= '0;
            rd2_e      <= '0;
            imm_e      <= '0;
            pc_e       <= '0;
            pc_plus4_e <= '0;
            rs1_e      <= '0;
            rs2_e      <= '0;
            rd_e       <= '0;
            ctrl_e     <= '0;
        end else begin
            rd1_e      <= rd1_d;
            rd2_e      <= rd2_d;
            imm_e      <= imm_d;
            pc_e       <= pc_d;
            pc_plus4_e <= pc_plus4_d;
            rs1_e      <= rs1_d;
            rs2_e      <= rs2_d;
            rd_e       <= flush_e ? 5'd0  : rd_d;
            ctrl_e     <= flush_e ? 10'd0 : ctrl_d;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_f, pc_f, pc_plus4_f;
    logic        stall_d, flush_d, flush_e;
    logic        reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic [4:0]  rs1_d, rs2_d;
    logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic [9:0]  ctrl_e;

    int checks = 0;
    int errors = 0;

    decode_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .instr_f(instr_f), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f),
        .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
        .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
        .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .ctrl_e(ctrl_e)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] v);
        reg_write_w = 1'b1; rd_w = r; result_w = v;
        tick();
        reg_write_w = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        instr_f = ins; pc_f = pc; pc_plus4_f = pc + 32'd4;
        tick();
        tick();
    endtask

    localparam logic [31:0] I_NOP  = 32'h0000_0013;
    localparam logic [31:0] I_LW   = 32'h0041_2283;
    localparam logic [31:0] I_ADD  = 32'h0000_00B3;
    localparam logic [31:0] I_SUB  = 32'h4031_00B3;
    localparam logic [31:0] I_SW   = 32'hFE51_2C23;
    localparam logic [31:0] I_LUI  = 32'h1234_50B7;
    localparam logic [31:0] I_BEQ  = 32'hFE00_0EE3;
    localparam logic [31:0] I_JAL  = 32'h0080_006F;
    localparam logic [31:0] I_RD7  = 32'h0003_8433;

    initial begin
        rst = 1'b0;
        instr_f = I_LW; pc_f = 32'h1234; pc_plus4_f = 32'h1238;
        stall_d = 1'b0; flush_d = 1'b0; flush_e = 1'b0;
        reg_write_w = 1'b1; rd_w = 5'd3; result_w = 32'hCAFE_F00D;
        tick(); tick(); tick();
        check("rst_rd1_e", rd1_e, 0);
        check("rst_rd2_e", rd2_e, 0);
        check("rst_imm_e", imm_e, 0);
        check("rst_pc_e", pc_e, 0);
        check("rst_pc4_e", pc_plus4_e, 0);
        check("rst_rs_e", {rs1_e, rs2_e, rd_e}, 0);
        check("rst_ctrl_e", ctrl_e, 0);
        check("rst_rs1_d", rs1_d, 0);

        reg_write_w = 1'b0;
        instr_f = I_NOP;
        #2 rst = 1'b1;
        tick(); tick();
        check("nop_ctrl", ctrl_e, 32'h001);
        check("nop_imm", imm_e, 0);

        wb(5'd2, 32'h100);
        issue(I_LW, 32'h40);
        check("lw_rd1", rd1_e, 32'h100);
        check("lw_imm", imm_e, 4);
        check("lw_rd", rd_e, 5);
        check("lw_ctrl", ctrl_e, 32'h031);
        check("lw_rs1_rs2", {rs1_e, rs2_e}, {2'd0, 5'd2, 5'd4});
        check("lw_pc", pc_e, 32'h40);
        check("lw_pc4", pc_plus4_e, 32'h44);
        check("x3_not_written_in_rst", dut.rf[3], 0);

        wb(5'd0, 32'hDEAD_BEEF);
        issue(I_ADD, 32'h50);
        check("x0_rd1", rd1_e, 0);
        check("x0_rd2", rd2_e, 0);
        check("add_ctrl", ctrl_e, 32'h001);

        wb(5'd3, 32'h7);
        issue(I_SUB, 32'h54);
        check("sub_ctrl", ctrl_e, 32'h081);
        check("sub_rd2", rd2_e, 32'h7);
        issue(I_SW, 32'h58);
        check("sw_imm", imm_e, 32'hFFFF_FFF8);
        check("sw_ctrl", ctrl_e, 32'h012);
        issue(I_LUI, 32'h5C);
        check("lui_imm", imm_e, 32'h1234_5000);
        check("lui_ctrl", ctrl_e, 0);

        instr_f = I_LW; pc_f = 32'h60; pc_plus4_f = 32'h64;
        tick();
        stall_d = 1'b1; instr_f = I_ADD; pc_f = 32'h70;
        tick();
        check("stall1_rs", {rs1_d, rs2_d}, {5'd2, 5'd4});
        tick();
        check("stall2_rs", {rs1_d, rs2_d}, {5'd2, 5'd4});
        check("stall2_rd_e", rd_e, 5);
        check("stall2_pc_e", pc_e, 32'h60);
        flush_d = 1'b1;
        tick();
        check("flushd_rs", {rs1_d, rs2_d}, 0);
        stall_d = 1'b0; flush_d = 1'b0;
        tick();
        check("flushd_ctrl_e", ctrl_e, 32'h001);
        check("flushd_pc_e", pc_e, 0);
        check("flushd_rd_e", rd_e, 0);
        flush_e = 1'b1;
        tick();
        check("flushe_ctrl", ctrl_e, 0);
        check("flushe_rd", rd_e, 0);
        flush_e = 1'b0;
        tick();
        check("after_flushe_ctrl", ctrl_e, 32'h001);
        check("after_flushe_rd", rd_e, 1);

        wb(5'd7, 32'h11);
        instr_f = I_RD7;
        tick();
        reg_write_w = 1'b1; rd_w = 5'd7; result_w = 32'h55;
        tick();
        reg_write_w = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
        check("bypass_rd1", rd1_e, 32'h55);
`else
        check("bypass_rd1", rd1_e, 32'h11);
`endif
        tick();
        check("post_write_rd1", rd1_e, 32'h55);

        issue(I_BEQ, 32'h80);
        check("beq_imm", imm_e, 32'hFFFF_FFFC);
        check("beq_ctrl", ctrl_e, 32'h084);
        issue(I_JAL, 32'h84);
        check("jal_imm", imm_e, 8);
        check("jal_jump", {31'd0, ctrl_e[3]}, 1);
        check("jal_ctrl", ctrl_e, 32'h049);

        issue(I_LW, 32'h90);
        #2 rst = 1'b0;
        #1;
        check("async_ctrl", ctrl_e, 0);
        check("async_rd1", rd1_e, 0);
        check("async_pc_e", pc_e, 0);
        #2 rst = 1'b1;
        tick();
        issue(I_LW, 32'h94);
        check("rf_cleared_x2", rd1_e, 0);
        check("post_rst_ctrl", ctrl_e, 32'h031);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register/immediate/data width.
REQ-002 Parameter ADDRESS_WIDTH, default 32: PC width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 instr_f  input  DATA_WIDTH  instruction from the fetch stage.
REQ-006 pc_f  input  ADDRESS_WIDTH  PC of instr_f.
REQ-007 pc_plus4_f  input  ADDRESS_WIDTH  pc_f+4.
REQ-008 stall_d  input  1  hold the IF/ID register.
REQ-009 flush_d  input  1  load a NOP into the IF/ID register.
REQ-010 flush_e  input  1  load a bubble into the ID/EX register.
REQ-011 reg_write_w  input  1  writeback enable.
REQ-012 rd_w  input  5  writeback destination.
REQ-013 result_w  input  DATA_WIDTH  writeback data.
REQ-014 rs1_d  output  5  instr_d[19:15], to the hazard unit.
REQ-015 rs2_d  output  5  instr_d[24:20], to the hazard unit.
REQ-016 rd1_e  output  DATA_WIDTH  registered rs1 operand.
REQ-017 rd2_e  output  DATA_WIDTH  registered rs2 operand.
REQ-018 imm_e  output  DATA_WIDTH  registered sign-extended immediate.
REQ-019 pc_e  output  ADDRESS_WIDTH  registered PC.
REQ-020 pc_plus4_e  output  ADDRESS_WIDTH  registered PC+4.
REQ-021 rs1_e  output  5  registered rs1.
REQ-022 rs2_e  output  5  registered rs2.
REQ-023 rd_e  output  5  registered rd.
REQ-024 ctrl_e  output  10  registered control bundle.

Function
REQ-025 IF/ID register (instr_d, pc_d, pc_plus4_d): flush_d loads 0x00000013 and zero PCs; otherwise stall_d holds; otherwise capture the _f inputs. flush_d has priority over stall_d.
REQ-026 Register file: 32 x DATA_WIDTH, x0 reads 0. A write occurs on the rising edge when reg_write_w=1 and rd_w!=0; rd_w=0 writes are discarded.
REQ-027 Immediate format by opcode:
- I-type (0000011, 0010011): I.
- 0100011: S.
- 1100011: B.
- 1101111: J.
- 0110111: U.
- Others: 0.
- All immediates sign-extended to DATA_WIDTH.
REQ-028 ctrl_e bits: [0] reg_write, [1] mem_write, [2] branch, [3] jump, [4] alu_src, [6:5] result_src (00 ALU, 01 mem, 10 pc+4), [9:7] alu_ctrl (000 add, 001 sub, 010 and, 011 or, 101 slt).
REQ-029 Decode per opcode:
- lw: reg_write, alu_src, result_src=01, add.
- sw: mem_write, alu_src, add.
- R-type and 0010011: reg_write, alu_ctrl from funct3/funct7[5]; sub only for R-type.
- beq: branch, sub.
- jal: reg_write, jump, result_src=10.
- Unsupported opcode: ctrl=0.
REQ-030 ID/EX register updates every cycle with no stall. flush_e forces ctrl_e=0 and rd_e=0 (bubble); the other fields are don't-care.
REQ-031 Latency: instruction on instr_f at edge N appears on the _e outputs after edge N+1.

Reset
REQ-032 With rst=0, asynchronously:
- IF/ID register holds NOP with zero PCs.
- All ID/EX outputs are 0.
- All 32 registers are 0.
REQ-033 Reset deassertion takes effect at the next rising edge. Reset mid-stream discards all in-flight instructions.

Configuration
REQ-034 Macro DECODE_WB_BYPASS_EN.
- Defined: a read of register r in the same cycle as a write to r (r!=0) returns result_w.
- Undefined: the read returns the old value; the hazard unit resolves the conflict.

Verification
REQ-035 Reset: rst=0 with arbitrary inputs -> all _e outputs 0. After release and a pipeline fill of 0x00000013, ctrl_e=0x001 and imm_e=0.
REQ-036 Decode: instr_f=0x00412283 (lw x5,4(x2)), x2=0x100 -> after 2 edges rd1_e=0x100, imm_e=4, rd_e=5, ctrl_e bits reg_write=1, alu_src=1, result_src=01.
REQ-037 x0 write: reg_write_w=1, rd_w=0, result_w=0xDEADBEEF -> a later read of x0 gives 0.
REQ-038 Stall/flush:
- stall_d=1 for 2 cycles -> instr_d held.
- stall_d=1 and flush_d=1 -> NOP loaded.
- flush_e=1 -> ctrl_e=0 next cycle.
REQ-039 Bypass: write x7=0x55 while reading x7 in the same cycle -> rd1_e=0x55 if DECODE_WB_BYPASS_EN is defined, else the old value.
REQ-040 Immediates:
- 0xFE000EE3 (beq, offset -4) -> imm_e=0xFFFFFFFC.
- 0x0080006F (jal +8) -> imm_e=8 with ctrl_e jump=1.
